// File: rtl/mips_pkg.sv
// mips_pkg: shared constants and types for the 5-stage MIPS pipeline.
//   DATA_W / REG_AW / ALUOP_W : default datapath, register-address and ALU-op widths
//   ctrl_t                    : packed EX/MEM/WB control bundle carried down the pipe
//   CTRL_BUBBLE               : control value of an inserted bubble (a nop to r0)
package mips_pkg;

  localparam int DATA_W  = 32;
  localparam int REG_AW  = 5;
  localparam int ALUOP_W = 4;

  typedef struct packed {
    logic               RegWrite;
    logic               MemRead;
    logic               MemWrite;
    logic               MemtoReg;
    logic               ALUSrc;
    logic [ALUOP_W-1:0] ALUOp;
  } ctrl_t;

  localparam ctrl_t CTRL_BUBBLE = ctrl_t'({(5 + ALUOP_W){1'b0}});

endpackage

// File: rtl/id_ex_stage_reg_load_use_detect.sv
// load_use_detect: purely combinational load-use hazard detection.
// Flags a hazard when the instruction sitting in EX is a valid load whose
// destination (non-zero) is read by the instruction currently in ID.
// Ports:
//   reset        in  active-low reset; forces stall low while asserted
//   ex_valid     in  EX slot holds a real instruction
//   ex_mem_read  in  EX instruction is a load
//   ex_rd        in  EX destination register
//   id_rs/id_rt  in  ID source register fields
//   id_uses_rs/rt in ID instruction actually reads that field
//   flush        in  ID instruction is being squashed anyway
//   haz          out raw hazard condition (selects a bubble)
//   stall        out freeze PC and IF/ID this cycle
module load_use_detect #(
  parameter int REG_AW = 5
) (
  input  logic              reset,
  input  logic              ex_valid,
  input  logic              ex_mem_read,
  input  logic [REG_AW-1:0] ex_rd,
  input  logic [REG_AW-1:0] id_rs,
  input  logic [REG_AW-1:0] id_rt,
  input  logic              id_uses_rs,
  input  logic              id_uses_rt,
  input  logic              flush,
  output logic              haz,
  output logic              stall
);

  logic ex_is_load_s;
  logic rs_match_s;
  logic rt_match_s;

  // Source/destination comparison; r0 as a load target never creates a dependency.
  always_comb begin
    ex_is_load_s = ex_valid & ex_mem_read & (ex_rd != {REG_AW{1'b0}});
    rs_match_s   = id_uses_rs & (id_rs == ex_rd);
    rt_match_s   = id_uses_rt & (id_rt == ex_rd);
    haz          = ex_is_load_s & (rs_match_s | rt_match_s);
    // A squashed ID instruction does not need the pipe frozen for it.
    stall        = haz & ~flush & reset;
  end

endmodule

// File: rtl/id_ex_stage_reg.sv
// id_ex_stage_reg: ID/EX pipeline register with load-use bubble insertion.
// Captures decoded operands, register addresses and control from ID and
// presents them to EX / the forwarding unit one cycle later. A load-use
// hazard loads a bubble and raises Stall for one cycle; Flush squashes the
// ID instruction; Hold freezes the whole register.
// Optional macro ID_EX_STATS_EN adds saturating BubbleCount / FlushCount.
// Ports:
//   clk, reset (async active-low)
//   Hold, Flush                     pipeline control
//   ID_* inputs                     decoded ID instruction
//   ID_EX_* outputs                 registered copy (UsesRs/UsesRt not carried)
//   ID_EX_Valid                     0 = bubble
//   Stall                           combinational; hold PC and IF/ID
//   BubbleCount, FlushCount         (ID_EX_STATS_EN only) event counters
module id_ex_stage_reg #(
  parameter int DATA_W  = mips_pkg::DATA_W,
  parameter int REG_AW  = mips_pkg::REG_AW,
  parameter int ALUOP_W = mips_pkg::ALUOP_W
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               Hold,
  input  logic               Flush,
  input  logic [REG_AW-1:0]  ID_rs,
  input  logic [REG_AW-1:0]  ID_rt,
  input  logic [REG_AW-1:0]  ID_RegWriteAddr,
  input  logic               ID_UsesRs,
  input  logic               ID_UsesRt,
  input  logic               ID_RegWrite,
  input  logic               ID_MemRead,
  input  logic               ID_MemWrite,
  input  logic               ID_MemtoReg,
  input  logic               ID_ALUSrc,
  input  logic [ALUOP_W-1:0] ID_ALUOp,
  input  logic [DATA_W-1:0]  ID_Data1,
  input  logic [DATA_W-1:0]  ID_Data2,
  input  logic [DATA_W-1:0]  ID_Imm,
  input  logic [DATA_W-1:0]  ID_PC,
  output logic [REG_AW-1:0]  ID_EX_rs,
  output logic [REG_AW-1:0]  ID_EX_rt,
  output logic [REG_AW-1:0]  ID_EX_RegWriteAddr,
  output logic               ID_EX_RegWrite,
  output logic               ID_EX_MemRead,
  output logic               ID_EX_MemWrite,
  output logic               ID_EX_MemtoReg,
  output logic               ID_EX_ALUSrc,
  output logic [ALUOP_W-1:0] ID_EX_ALUOp,
  output logic [DATA_W-1:0]  ID_EX_Data1,
  output logic [DATA_W-1:0]  ID_EX_Data2,
  output logic [DATA_W-1:0]  ID_EX_Imm,
  output logic [DATA_W-1:0]  ID_EX_PC,
  output logic               ID_EX_Valid,
`ifdef ID_EX_STATS_EN
  output logic [31:0]        BubbleCount,
  output logic [31:0]        FlushCount,
`endif
  output logic               Stall
);

  import mips_pkg::*;

  ctrl_t              ctrl_r;
  ctrl_t              id_ctrl_s;
  logic               valid_r;
  logic [REG_AW-1:0]  rs_r;
  logic [REG_AW-1:0]  rt_r;
  logic [REG_AW-1:0]  rd_r;
  logic [DATA_W-1:0]  data1_r;
  logic [DATA_W-1:0]  data2_r;
  logic [DATA_W-1:0]  imm_r;
  logic [DATA_W-1:0]  pc_r;
  logic               haz_s;
  logic               stall_s;
  logic               load_bubble_s;

  load_use_detect #(
    .REG_AW(REG_AW)
  ) u_load_use_detect (
    .reset      (reset),
    .ex_valid   (valid_r),
    .ex_mem_read(ctrl_r.MemRead),
    .ex_rd      (rd_r),
    .id_rs      (ID_rs),
    .id_rt      (ID_rt),
    .id_uses_rs (ID_UsesRs),
    .id_uses_rt (ID_UsesRt),
    .flush      (Flush),
    .haz        (haz_s),
    .stall      (stall_s)
  );

  // Bundle incoming control and decide whether this edge loads a bubble.
  always_comb begin
    id_ctrl_s.RegWrite = ID_RegWrite;
    id_ctrl_s.MemRead  = ID_MemRead;
    id_ctrl_s.MemWrite = ID_MemWrite;
    id_ctrl_s.MemtoReg = ID_MemtoReg;
    id_ctrl_s.ALUSrc   = ID_ALUSrc;
    id_ctrl_s.ALUOp    = ID_ALUOp;
    load_bubble_s      = Flush | haz_s;
  end

  // Pipeline register: Hold > Flush/hazard bubble > normal load.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ctrl_r  <= CTRL_BUBBLE;
      valid_r <= 1'b0;
      rs_r    <= {REG_AW{1'b0}};
      rt_r    <= {REG_AW{1'b0}};
      rd_r    <= {REG_AW{1'b0}};
      data1_r <= {DATA_W{1'b0}};
      data2_r <= {DATA_W{1'b0}};
      imm_r   <= {DATA_W{1'b0}};
      pc_r    <= {DATA_W{1'b0}};
    end else if (Hold) begin
      ctrl_r  <= ctrl_r;
      valid_r <= valid_r;
      rs_r    <= rs_r;
      rt_r    <= rt_r;
      rd_r    <= rd_r;
      data1_r <= data1_r;
      data2_r <= data2_r;
      imm_r   <= imm_r;
      pc_r    <= pc_r;
    end else if (load_bubble_s) begin
      // Zeroed RegWriteAddr keeps the bubble invisible to forwarding.
      ctrl_r  <= CTRL_BUBBLE;
      valid_r <= 1'b0;
      rs_r    <= {REG_AW{1'b0}};
      rt_r    <= {REG_AW{1'b0}};
      rd_r    <= {REG_AW{1'b0}};
      data1_r <= {DATA_W{1'b0}};
      data2_r <= {DATA_W{1'b0}};
      imm_r   <= {DATA_W{1'b0}};
      pc_r    <= {DATA_W{1'b0}};
    end else begin
      ctrl_r  <= id_ctrl_s;
      valid_r <= 1'b1;
      rs_r    <= ID_rs;
      rt_r    <= ID_rt;
      rd_r    <= ID_RegWriteAddr;
      data1_r <= ID_Data1;
      data2_r <= ID_Data2;
      imm_r   <= ID_Imm;
      pc_r    <= ID_PC;
    end
  end

  // Drive outputs straight from the register contents.
  always_comb begin
    ID_EX_rs           = rs_r;
    ID_EX_rt           = rt_r;
    ID_EX_RegWriteAddr = rd_r;
    ID_EX_RegWrite     = ctrl_r.RegWrite;
    ID_EX_MemRead      = ctrl_r.MemRead;
    ID_EX_MemWrite     = ctrl_r.MemWrite;
    ID_EX_MemtoReg     = ctrl_r.MemtoReg;
    ID_EX_ALUSrc       = ctrl_r.ALUSrc;
    ID_EX_ALUOp        = ctrl_r.ALUOp;
    ID_EX_Data1        = data1_r;
    ID_EX_Data2        = data2_r;
    ID_EX_Imm          = imm_r;
    ID_EX_PC           = pc_r;
    ID_EX_Valid        = valid_r;
    Stall              = stall_s;
  end

`ifdef ID_EX_STATS_EN
  logic [31:0] bubble_cnt_r;
  logic [31:0] flush_cnt_r;

  // Saturating event counters; a held cycle loads nothing so counts nothing.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      bubble_cnt_r <= 32'd0;
      flush_cnt_r  <= 32'd0;
    end else if (Hold) begin
      bubble_cnt_r <= bubble_cnt_r;
      flush_cnt_r  <= flush_cnt_r;
    end else if (Flush) begin
      bubble_cnt_r <= bubble_cnt_r;
      if (flush_cnt_r != 32'hFFFF_FFFF) begin
        flush_cnt_r <= flush_cnt_r + 32'd1;
      end else begin
        flush_cnt_r <= flush_cnt_r;
      end
    end else if (haz_s) begin
      flush_cnt_r <= flush_cnt_r;
      if (bubble_cnt_r != 32'hFFFF_FFFF) begin
        bubble_cnt_r <= bubble_cnt_r + 32'd1;
      end else begin
        bubble_cnt_r <= bubble_cnt_r;
      end
    end else begin
      bubble_cnt_r <= bubble_cnt_r;
      flush_cnt_r  <= flush_cnt_r;
    end
  end

  // Expose the counters.
  always_comb begin
    BubbleCount = bubble_cnt_r;
    FlushCount  = flush_cnt_r;
  end
`endif

endmodule

// File: tb/tb_id_ex_stage_reg.sv
// tb_id_ex_stage_reg: table-driven self-checking bench for id_ex_stage_reg.
// Each table row is one ID-stage cycle; a reference model predicts the
// registered outputs, pushes them to a scoreboard queue, and they are
// popped and compared after the next rising edge. Stall is compared
// against the hand-derived value in the row. Reset with random inputs and
// reset during a stall are hand-written sequences.
// Define ID_EX_STATS_EN to also check BubbleCount / FlushCount.
module tb_id_ex_stage_reg;

  typedef struct packed {
    logic        valid;
    logic        rw;
    logic        mr;
    logic        mw;
    logic        m2r;
    logic        as;
    logic [3:0]  aluop;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [31:0] d1;
    logic [31:0] d2;
    logic [31:0] imm;
    logic [31:0] pc;
  } out_t;

  typedef struct {
    logic       hold;
    logic       flush;
    logic [4:0] rs;
    logic [4:0] rt;
    logic [4:0] rd;
    logic       urs;
    logic       urt;
    logic       rw;
    logic       mr;
    logic [3:0] aluop;
    logic       exp_stall;
    logic       exp_valid;
    logic [4:0] exp_rd;
  } vec_t;

  logic        clk;
  logic        reset;
  logic        Hold, Flush;
  logic [4:0]  ID_rs, ID_rt, ID_RegWriteAddr;
  logic        ID_UsesRs, ID_UsesRt;
  logic        ID_RegWrite, ID_MemRead, ID_MemWrite, ID_MemtoReg, ID_ALUSrc;
  logic [3:0]  ID_ALUOp;
  logic [31:0] ID_Data1, ID_Data2, ID_Imm, ID_PC;
  logic [4:0]  ID_EX_rs, ID_EX_rt, ID_EX_RegWriteAddr;
  logic        ID_EX_RegWrite, ID_EX_MemRead, ID_EX_MemWrite, ID_EX_MemtoReg, ID_EX_ALUSrc;
  logic [3:0]  ID_EX_ALUOp;
  logic [31:0] ID_EX_Data1, ID_EX_Data2, ID_EX_Imm, ID_EX_PC;
  logic        ID_EX_Valid;
  logic        Stall;
`ifdef ID_EX_STATS_EN
  logic [31:0] BubbleCount, FlushCount;
  int          m_bc;
  int          m_fc;
`endif

  out_t dut_vec;
  out_t m_out;
  out_t sb[$];
  vec_t tbl[27];
  int   total;
  int   bad;

  id_ex_stage_reg dut (
    .clk(clk), .reset(reset), .Hold(Hold), .Flush(Flush),
    .ID_rs(ID_rs), .ID_rt(ID_rt), .ID_RegWriteAddr(ID_RegWriteAddr),
    .ID_UsesRs(ID_UsesRs), .ID_UsesRt(ID_UsesRt),
    .ID_RegWrite(ID_RegWrite), .ID_MemRead(ID_MemRead), .ID_MemWrite(ID_MemWrite),
    .ID_MemtoReg(ID_MemtoReg), .ID_ALUSrc(ID_ALUSrc), .ID_ALUOp(ID_ALUOp),
    .ID_Data1(ID_Data1), .ID_Data2(ID_Data2), .ID_Imm(ID_Imm), .ID_PC(ID_PC),
    .ID_EX_rs(ID_EX_rs), .ID_EX_rt(ID_EX_rt), .ID_EX_RegWriteAddr(ID_EX_RegWriteAddr),
    .ID_EX_RegWrite(ID_EX_RegWrite), .ID_EX_MemRead(ID_EX_MemRead),
    .ID_EX_MemWrite(ID_EX_MemWrite), .ID_EX_MemtoReg(ID_EX_MemtoReg),
    .ID_EX_ALUSrc(ID_EX_ALUSrc), .ID_EX_ALUOp(ID_EX_ALUOp),
    .ID_EX_Data1(ID_EX_Data1), .ID_EX_Data2(ID_EX_Data2),
    .ID_EX_Imm(ID_EX_Imm), .ID_EX_PC(ID_EX_PC), .ID_EX_Valid(ID_EX_Valid),
`ifdef ID_EX_STATS_EN
    .BubbleCount(BubbleCount), .FlushCount(FlushCount),
`endif
    .Stall(Stall)
  );

  assign dut_vec = {ID_EX_Valid, ID_EX_RegWrite, ID_EX_MemRead, ID_EX_MemWrite,
                    ID_EX_MemtoReg, ID_EX_ALUSrc, ID_EX_ALUOp, ID_EX_rs, ID_EX_rt,
                    ID_EX_RegWriteAddr, ID_EX_Data1, ID_EX_Data2, ID_EX_Imm, ID_EX_PC};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [159:0] act, input logic [159:0] exp);
    total = total + 1;
    if (act !== exp) begin
      bad = bad + 1;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic hold, input logic flush, input logic [4:0] rs,
                              input logic [4:0] rt, input logic [4:0] rd, input logic urs,
                              input logic urt, input logic rw, input logic mr,
                              input logic [3:0] aluop, input logic es, input logic ev,
                              input logic [4:0] erd);
    vec_t v;
    v.hold = hold; v.flush = flush; v.rs = rs; v.rt = rt; v.rd = rd;
    v.urs = urs; v.urt = urt; v.rw = rw; v.mr = mr; v.aluop = aluop;
    v.exp_stall = es; v.exp_valid = ev; v.exp_rd = erd;
    return v;
  endfunction

  task automatic drive(input vec_t v, input int idx);
    Hold = v.hold; Flush = v.flush;
    ID_rs = v.rs; ID_rt = v.rt; ID_RegWriteAddr = v.rd;
    ID_UsesRs = v.urs; ID_UsesRt = v.urt;
    ID_RegWrite = v.rw; ID_MemRead = v.mr;
    ID_MemWrite = ~v.rw & ~v.mr;
    ID_MemtoReg = v.mr; ID_ALUSrc = v.mr; ID_ALUOp = v.aluop;
    ID_Data1 = 32'hA000_0000 | 32'(idx);
    ID_Data2 = 32'hB000_0000 | 32'(idx);
    ID_Imm   = 32'hC000_0000 | 32'(idx);
    ID_PC    = 32'h0040_0000 + 32'(idx * 4);
  endtask

  // One ID cycle: drive, check Stall, predict, then compare after the edge.
  task automatic step(input vec_t v, input int idx);
    logic haz;
    out_t e;
    @(negedge clk);
    drive(v, idx);
    #1;
    haz = m_out.valid & m_out.mr & (m_out.rd != 5'd0) &
          ((v.urs & (v.rs == m_out.rd)) | (v.urt & (v.rt == m_out.rd)));
    chk($sformatf("stall[%0d]", idx), 160'(Stall), 160'(v.exp_stall));
    if (v.hold) e = m_out;
    else if (v.flush | haz) e = '0;
    else e = {1'b1, ID_RegWrite, ID_MemRead, ID_MemWrite, ID_MemtoReg, ID_ALUSrc,
              ID_ALUOp, ID_rs, ID_rt, ID_RegWriteAddr, ID_Data1, ID_Data2, ID_Imm, ID_PC};
`ifdef ID_EX_STATS_EN
    if (!v.hold && v.flush) m_fc = m_fc + 1;
    else if (!v.hold && haz) m_bc = m_bc + 1;
`endif
    sb.push_back(e);
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      chk("scoreboard_empty", 160'd0, 160'd1);
    end else begin
      e = sb.pop_front();
      chk($sformatf("regs[%0d]", idx), 160'(dut_vec), 160'(e));
      chk($sformatf("valid[%0d]", idx), 160'(ID_EX_Valid), 160'(v.exp_valid));
      chk($sformatf("rd[%0d]", idx), 160'(ID_EX_RegWriteAddr), 160'(v.exp_rd));
      m_out = e;
    end
  endtask

  initial begin
    total = 0; bad = 0;
    m_out = '0;
`ifdef ID_EX_STATS_EN
    m_bc = 0; m_fc = 0;
`endif
    //           hold  flush rs     rt     rd     urs   urt   rw    mr    aluop  stall valid rd
    tbl[0]  = mk(1'b0, 1'b0, 5'd1,  5'd2,  5'd3,  1'b1, 1'b1, 1'b1, 1'b0, 4'd2, 1'b0, 1'b1, 5'd3);
    tbl[1]  = mk(1'b0, 1'b0, 5'd1,  5'd5,  5'd5,  1'b1, 1'b0, 1'b1, 1'b1, 4'd0, 1'b0, 1'b1, 5'd5);
    tbl[2]  = mk(1'b0, 1'b0, 5'd5,  5'd1,  5'd6,  1'b1, 1'b1, 1'b1, 1'b0, 4'd2, 1'b1, 1'b0, 5'd0);
    tbl[3]  = mk(1'b0, 1'b0, 5'd5,  5'd1,  5'd6,  1'b1, 1'b1, 1'b1, 1'b0, 4'd2, 1'b0, 1'b1, 5'd6);
    tbl[4]  = mk(1'b0, 1'b0, 5'd1,  5'd0,  5'd0,  1'b1, 1'b0, 1'b1, 1'b1, 4'd0, 1'b0, 1'b1, 5'd0);
    tbl[5]  = mk(1'b0, 1'b0, 5'd0,  5'd0,  5'd7,  1'b1, 1'b1, 1'b1, 1'b0, 4'd2, 1'b0, 1'b1, 5'd7);
    tbl[6]  = mk(1'b0, 1'b0, 5'd1,  5'd5,  5'd5,  1'b1, 1'b0, 1'b1, 1'b1, 4'd0, 1'b0, 1'b1, 5'd5);
    tbl[7]  = mk(1'b0, 1'b0, 5'd2,  5'd5,  5'd8,  1'b1, 1'b0, 1'b0, 1'b0, 4'd6, 1'b0, 1'b1, 5'd8);
    tbl[8]  = mk(1'b0, 1'b0, 5'd1,  5'd5,  5'd5,  1'b1, 1'b0, 1'b1, 1'b1, 4'd0, 1'b0, 1'b1, 5'd5);
    tbl[9]  = mk(1'b0, 1'b1, 5'd5,  5'd5,  5'd9,  1'b1, 1'b1, 1'b1, 1'b0, 4'd2, 1'b0, 1'b0, 5'd0);
    tbl[10] = mk(1'b0, 1'b0, 5'd1,  5'd4,  5'd4,  1'b1, 1'b0, 1'b1, 1'b1, 4'd0, 1'b0, 1'b1, 5'd4);
    tbl[11] = mk(1'b1, 1'b0, 5'd4,  5'd2,  5'd10, 1'b1, 1'b1, 1'b1, 1'b0, 4'd2, 1'b1, 1'b1, 5'd4);
    tbl[12] = mk(1'b1, 1'b0, 5'd4,  5'd3,  5'd11, 1'b1, 1'b1, 1'b1, 1'b0, 4'd3, 1'b1, 1'b1, 5'd4);
    tbl[13] = mk(1'b1, 1'b0, 5'd2,  5'd4,  5'd11, 1'b1, 1'b1, 1'b1, 1'b0, 4'd3, 1'b1, 1'b1, 5'd4);
    tbl[14] = mk(1'b0, 1'b0, 5'd1,  5'd4,  5'd12, 1'b1, 1'b1, 1'b1, 1'b0, 4'd2, 1'b1, 1'b0, 5'd0);
    tbl[15] = mk(1'b0, 1'b0, 5'd1,  5'd4,  5'd12, 1'b1, 1'b1, 1'b1, 1'b0, 4'd2, 1'b0, 1'b1, 5'd12);
    tbl[16] = mk(1'b1, 1'b0, 5'd1,  5'd2,  5'd13, 1'b1, 1'b1, 1'b1, 1'b0, 4'd1, 1'b0, 1'b1, 5'd12);
    tbl[17] = mk(1'b1, 1'b0, 5'd3,  5'd4,  5'd14, 1'b1, 1'b1, 1'b1, 1'b0, 4'd5, 1'b0, 1'b1, 5'd12);
    tbl[18] = mk(1'b1, 1'b0, 5'd5,  5'd6,  5'd15, 1'b1, 1'b1, 1'b1, 1'b0, 4'd7, 1'b0, 1'b1, 5'd12);
    tbl[19] = mk(1'b0, 1'b0, 5'd7,  5'd8,  5'd16, 1'b1, 1'b1, 1'b1, 1'b0, 4'd9, 1'b0, 1'b1, 5'd16);
    tbl[20] = mk(1'b0, 1'b0, 5'd1,  5'd5,  5'd5,  1'b1, 1'b0, 1'b1, 1'b1, 4'd0, 1'b0, 1'b1, 5'd5);
    tbl[21] = mk(1'b0, 1'b0, 5'd5,  5'd6,  5'd6,  1'b1, 1'b0, 1'b1, 1'b1, 4'd0, 1'b1, 1'b0, 5'd0);
    tbl[22] = mk(1'b0, 1'b0, 5'd5,  5'd6,  5'd6,  1'b1, 1'b0, 1'b1, 1'b1, 4'd0, 1'b0, 1'b1, 5'd6);
    tbl[23] = mk(1'b0, 1'b0, 5'd6,  5'd1,  5'd7,  1'b1, 1'b1, 1'b1, 1'b0, 4'd2, 1'b1, 1'b0, 5'd0);
    tbl[24] = mk(1'b0, 1'b0, 5'd6,  5'd1,  5'd7,  1'b1, 1'b1, 1'b1, 1'b0, 4'd2, 1'b0, 1'b1, 5'd7);
    tbl[25] = mk(1'b1, 1'b1, 5'd2,  5'd3,  5'd20, 1'b1, 1'b1, 1'b1, 1'b0, 4'd2, 1'b0, 1'b1, 5'd7);
    tbl[26] = mk(1'b0, 1'b1, 5'd2,  5'd3,  5'd20, 1'b1, 1'b1, 1'b1, 1'b0, 4'd2, 1'b0, 1'b0, 5'd0);

    // Reset held with random inputs: everything must read zero.
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      Hold = 1'b0; Flush = 1'b0;
      ID_rs = 5'($urandom); ID_rt = 5'($urandom); ID_RegWriteAddr = 5'($urandom);
      ID_UsesRs = 1'b1; ID_UsesRt = 1'b1;
      ID_RegWrite = 1'($urandom); ID_MemRead = 1'b1; ID_MemWrite = 1'($urandom);
      ID_MemtoReg = 1'($urandom); ID_ALUSrc = 1'($urandom); ID_ALUOp = 4'($urandom);
      ID_Data1 = $urandom; ID_Data2 = $urandom; ID_Imm = $urandom; ID_PC = $urandom;
      @(posedge clk);
      #1;
      chk("reset_regs", 160'(dut_vec), 160'd0);
      chk("reset_stall", 160'(Stall), 160'd0);
    end
`ifdef ID_EX_STATS_EN
    chk("reset_bubblecnt", 160'(BubbleCount), 160'd0);
    chk("reset_flushcnt", 160'(FlushCount), 160'd0);
`endif
    @(negedge clk);
    reset = 1'b1;

    for (int i = 0; i < 27; i++) begin
      step(tbl[i], i);
    end

`ifdef ID_EX_STATS_EN
    chk("bubble_count", 160'(BubbleCount), 160'(m_bc));
    chk("flush_count", 160'(FlushCount), 160'(m_fc));
    chk("bubble_count_abs", 160'(BubbleCount), 160'd4);
    chk("flush_count_abs", 160'(FlushCount), 160'd2);
`endif

    // Reset during a stall: state and Stall clear without waiting for a clock.
    step(mk(1'b0, 1'b0, 5'd1, 5'd5, 5'd5, 1'b1, 1'b0, 1'b1, 1'b1, 4'd0, 1'b0, 1'b1, 5'd5), 30);
    @(negedge clk);
    drive(mk(1'b0, 1'b0, 5'd5, 5'd2, 5'd6, 1'b1, 1'b1, 1'b1, 1'b0, 4'd2, 1'b0, 1'b0, 5'd0), 31);
    #1;
    chk("midstall_stall_before", 160'(Stall), 160'd1);
    #1;
    reset = 1'b0;
    #1;
    chk("midstall_stall_after", 160'(Stall), 160'd0);
    chk("midstall_regs", 160'(dut_vec), 160'd0);
    @(posedge clk);
    #1;
    chk("midstall_regs_edge", 160'(dut_vec), 160'd0);
`ifdef ID_EX_STATS_EN
    chk("midstall_bubblecnt", 160'(BubbleCount), 160'd0);
`endif
    @(negedge clk);
    reset = 1'b1;
    m_out = '0;
    step(tbl[0], 40);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/id_ex_stage_reg.md
Name: id_ex_stage_reg

Overview:
- ID/EX pipeline register with integrated load-use hazard detection for the 5-stage MIPS pipeline.
- Captures decoded operands, register addresses and control from ID.
- Presents them to EX and to the forwarding unit as ID_EX_rs, ID_EX_rt and ID_EX_RegWriteAddr.
- Inserts one bubble on a load-use hazard, asserts Stall to freeze PC and IF/ID, and handles branch/jump flush and whole-pipe memory hold.

Parameters:
DATA_W, 32, datapath width
REG_AW, 5, register address width
ALUOP_W, 4, ALU operation code width

Ports:
clk  in  1  pipeline clock
reset  in  1  asynchronous, active-low reset
Hold  in  1  memory wait; freeze all contents
Flush  in  1  branch/jump taken in EX; squash the ID instruction
ID_rs  in  REG_AW  rs field of the ID instruction
ID_rt  in  REG_AW  rt field
ID_RegWriteAddr  in  REG_AW  destination register
ID_UsesRs  in  1  instruction reads rs
ID_UsesRt  in  1  instruction reads rt
ID_RegWrite  in  1  control
ID_MemRead  in  1  control
ID_MemWrite  in  1  control
ID_MemtoReg  in  1  control
ID_ALUSrc  in  1  control
ID_ALUOp  in  ALUOP_W  control
ID_Data1  in  DATA_W  register file read port 1
ID_Data2  in  DATA_W  register file read port 2
ID_Imm  in  DATA_W  extended immediate
ID_PC  in  DATA_W  PC+4 of the ID instruction
ID_EX_<field>  out  same as input  registered copy of every ID_* field except UsesRs/UsesRt
ID_EX_Valid  out  1  register holds a real instruction (0 = bubble)
Stall  out  1  combinational; hold PC and IF/ID this cycle

Behaviour:
- Reset (reset=0, asynchronous): every ID_EX_* output and ID_EX_Valid go to 0. The register then holds a bubble equal to a nop to r0.
- Hazard condition (combinational):
  - haz = ID_EX_Valid & ID_EX_MemRead & (ID_EX_RegWriteAddr != 0) & ((ID_UsesRs & ID_rs == ID_EX_RegWriteAddr) | (ID_UsesRt & ID_rt == ID_EX_RegWriteAddr)).
  - Stall = haz & ~Flush. Stall is 0 while reset is asserted.
- Priority at each rising clk:
  1. Hold=1: all registers keep their values. Stall is still driven from haz.
  2. Flush=1: load a bubble. All control outputs, ID_EX_Valid, rs, rt and RegWriteAddr become 0. Data fields are don't-care and are loaded as 0.
  3. haz=1: load a bubble, as in 2.
  4. Otherwise: load every ID_* field and set ID_EX_Valid=1.
- Latency: 1 cycle from ID inputs to ID_EX outputs.
- Load-use timing:
  - Stall is asserted for exactly one cycle, because the inserted bubble has MemRead=0.
  - Back-to-back load-use chains each stall once.
- Simultaneous Flush and haz: Flush wins and Stall=0. The dependent instruction is squashed anyway.
- Simultaneous Hold and Flush: Hold wins. The upstream stage keeps Flush asserted until Hold drops.
- A zeroed bubble never matches in the forwarding unit, because its RegWriteAddr is 0.
- Reset mid-stall: all state clears immediately, and Stall falls in the same cycle.

Optional Feature:
- Macro: ID_EX_STATS_EN.
- When defined:
  - Adds outputs BubbleCount [31:0] and FlushCount [31:0].
  - BubbleCount increments on each clock where a haz bubble is loaded.
  - FlushCount increments on each clock where a flush bubble is loaded.
  - Neither counter increments while Hold=1.
  - Both counters saturate at all-ones and reset to 0.
- When undefined: the outputs and counters are absent, and the remaining behaviour is identical.

Decomposition:
- Shared package mips_pkg holds:
  - DATA_W, REG_AW and ALUOP_W constants
  - a packed typedef ctrl_t {RegWrite, MemRead, MemWrite, MemtoReg, ALUSrc, ALUOp}
  - a localparam CTRL_BUBBLE (all zero)
- Natural sub-module: load_use_detect, the pure combinational haz/Stall logic. It can be reused by a future EX-stage branch-hazard unit.

Test Plan:
- Reset: hold reset=0 with random inputs -> all outputs 0 and Stall=0. Release reset and present add r3,r1,r2 -> next cycle ID_EX_RegWriteAddr=3 and ID_EX_Valid=1.
- Load-use: lw r5 in EX, then ID add r6,r5,r1 (UsesRs=1) -> Stall=1 for exactly one cycle and a bubble appears in ID/EX. The next cycle loads the add with Stall=0.
- No false hazard:
  - lw r0 followed by a use of r0 -> Stall=0.
  - lw r5 followed by an instruction with rt=5 and UsesRt=0 -> Stall=0.
- Flush and hazard together: Flush=1 in the same cycle as a load-use match -> Stall=0, the bubble is loaded, and ID_EX_RegWriteAddr=0.
- Hold: Hold=1 for 3 cycles while the ID inputs change -> outputs unchanged. The first cycle after Hold drops loads the current ID values.
- Stats (ID_EX_STATS_EN): 2 load-use stalls and 1 flush, with a Hold during one haz cycle -> BubbleCount=2, FlushCount=1.
